fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Serial transmitter that drains the byte FIFO and sends each byte as an asynchronous UART frame on a single output pin. Sits on the read side of the FIFO: it watches the FIFO's empty flag, captures the show-ahead data word, and pulses the FIFO's edge-detected read strobe once per byte. Together with the FIFO it forms the board's debug/console TX path.

## Interface
- CLK_FREQ, 27000000: clock frequency in Hz.
- BAUD, 115200: line rate in bit/s; divisor DIV = CLK_FREQ / BAUD (integer truncation, must be ≥ 4).
- DATA_WIDTH, 8: bits per frame payload, LSB first.

- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clock edge).
- tx_enable  in  1  1 = frames may start; 0 = no new frame starts (a frame in progress completes).
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO show-ahead output (word at read pointer, valid while fifo_empty = 0).
- fifo_read_en  out  1  FIFO read strobe; the FIFO advances on its rising edge.
- tx  out  1  UART serial line, idle high.
- busy  out  1  high whenever a frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: tx = 1, busy = 0. On an edge with tx_enable = 1 and fifo_empty = 0: shift register <= fifo_data, fifo_read_en <= 1, bit counter <= 0, baud counter <= 0, state <= START.
- fifo_read_en is high for exactly one cycle (first START cycle), then 0 until the next capture; guarantees a clean 0→1 edge per byte because frames last ≥ 10·DIV cycles.
- START: tx = 0 for DIV cycles, then DATA.
- DATA: tx = shift_reg[0]; after DIV cycles shift right, increment bit counter; after DATA_WIDTH bits go to PARITY (macro) or STOP.
- STOP: tx = 1 for DIV cycles, then IDLE.
- Baud counter: width clog2(DIV), counts 0..DIV-1, wraps to 0 at bit boundary; no fractional accumulation.
- busy = 1 in every state except IDLE.
- tx_enable dropping mid-frame has no effect until the frame reaches IDLE.
- Data captured in IDLE is held in the shift register; fifo_data changes after the pop do not affect the frame.

## Timing
- Reset values: tx = 1, fifo_read_en = 0, busy = 0, state IDLE, counters 0.
- Reset mid-frame: outputs return to reset values on the edge reset is sampled low; the popped byte is discarded; no partial frame resumes.
- Latency: fifo_empty low sampled at edge N → tx = 0, busy = 1, fifo_read_en = 1 after edge N.
- Frame length: (2 + DATA_WIDTH)·DIV cycles; (3 + DATA_WIDTH)·DIV with parity.
- Back-to-back: after STOP ends, exactly one IDLE cycle (tx = 1), so consecutive frames are separated by DIV + 1 high cycles including the stop bit.
- Empty flag rising during a frame is ignored; only sampled in IDLE.

## Configuration
- FIFO_UART_TX_PARITY_EN defined: PARITY state inserted after DATA for DIV cycles; tx = XOR of all captured data bits (even parity). Frame = 11 bits at DATA_WIDTH = 8.
- Not defined: no PARITY state; 8N1 frame, 10 bits.

## Test plan
All with CLK_FREQ = 1000000, BAUD = 100000 (DIV = 10), DATA_WIDTH = 8.
- Reset held low 5 cycles, fifo_empty = 0 → tx = 1, busy = 0, fifo_read_en = 0 throughout; first frame starts on the first edge after release.
- Single byte 0xA5 → fifo_read_en one 1-cycle pulse; tx = 0 ×10, bits 1,0,1,0,0,1,0,1 ×10 each, 1 ×10; busy high 100 cycles, then 0.
- Three bytes 0x01, 0x80, 0xFF queued → three read pulses, 3 frames, each separated by 11 high cycles; decoded stream 0x01, 0x80, 0xFF.
- tx_enable = 0 with byte 0x55 pending → no pulse, tx high; raise tx_enable → frame starts next edge. Drop tx_enable in bit 3 → frame finishes, no new frame.
- Reset asserted at DATA bit 4 of 0x3C → tx = 1, busy = 0 next edge; after release, next FIFO byte sent with a full frame.
- Parity build, byte 0x07 → parity bit 1, frame 110 cycles; byte 0x03 → parity 0.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// Purpose: groups the FIFO read side and the UART line signals of fifo_uart_tx.
// master = the transmitter (consumes FIFO flags/data, drives strobe/line/busy);
// slave  = the FIFO/board side (drives enable/flags/data, observes the rest).
interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_enable;     // 1 = new frames may start
    logic                  fifo_empty;    // FIFO empty flag
    logic [DATA_WIDTH-1:0] fifo_data;     // FIFO show-ahead word
    logic                  fifo_read_en;  // one-cycle read strobe, FIFO pops on its rising edge
    logic                  tx;            // UART line, idle high
    logic                  busy;          // frame in progress

    modport master (
        input  tx_enable,
        input  fifo_empty,
        input  fifo_data,
        output fifo_read_en,
        output tx,
        output busy
    );

    modport slave (
        output tx_enable,
        output fifo_empty,
        output fifo_data,
        input  fifo_read_en,
        input  tx,
        input  busy
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Purpose: drains a show-ahead byte FIFO into asynchronous UART frames (start, LSB-first data, [parity], stop).
// Latency: byte seen (tx_enable=1, fifo_empty=0) at edge N -> tx=0, busy=1, fifo_read_en=1 right after edge N.
// Backpressure: holds off while fifo_empty=1 or tx_enable=0; a started frame always runs to completion.
//
// Ports: clock (rising edge), reset (synchronous, active low), bus (fifo_uart_tx_if.master:
//   tx_enable, fifo_empty, fifo_data in; fifo_read_en, tx, busy out).
// Optional macro FIFO_UART_TX_PARITY_EN: adds an even-parity bit between data and stop.
// Bit period DIV = CLK_FREQ / BAUD clock cycles (truncated); DIV must be at least 4.
module fifo_uart_tx #(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD       = 115200,
    parameter int DATA_WIDTH = 8
) (
    input  logic           clock,
    input  logic           reset,
    fifo_uart_tx_if.master bus
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  read_en_q, read_en_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  baud_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    // Next-state and next-output logic. Outputs are computed from the next
    // state so the line, strobe and busy come straight from flops.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        read_en_d = 1'b0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        baud_end  = (baud_q == BAUD_LAST);
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        // Bit-period counter runs in every framing state and wraps on the
        // bit boundary; it therefore always sits at 0 while idle.
        if (state_q != IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.tx_enable && !bus.fifo_empty) begin
                    state_d   = START;
                    shift_d   = bus.fifo_data;
                    read_en_d = 1'b1;
                    bit_d     = '0;
                    baud_d    = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_d  = ^bus.fifo_data;
`endif
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            read_en_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            read_en_q <= read_en_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign bus.fifo_read_en = read_en_q;
    assign bus.tx           = tx_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-backed FIFO model, a line decoder that
// samples tx at mid-bit, table-driven single-frame vectors, hand-written
// reset/enable/back-to-back sequences and a randomized drain phase.
module tb_fifo_uart_tx;
    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int DW       = 8;
    localparam int DIV      = CLK_FREQ / BAUD;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS    = DW + 3;
`else
    localparam int NBITS    = DW + 2;
`endif
    localparam int FL       = NBITS * DIV;

    logic clock = 1'b0;
    logic reset = 1'b0;

    fifo_uart_tx_if #(.DATA_WIDTH(DW)) bus ();

    fifo_uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .DATA_WIDTH (DW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO model: show-ahead word from a queue, pops on each rising edge of the strobe.
    logic [7:0] fq[$];
    int         rises = 0;
    initial begin
        logic rd_prev;
        rd_prev        = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
        forever begin
            @(posedge clock);
            #1;
            if (bus.fifo_read_en === 1'b1 && !rd_prev) begin
                rises++;
                if (fq.size() > 0) void'(fq.pop_front());
            end
            rd_prev        = (bus.fifo_read_en === 1'b1);
            bus.fifo_empty = (fq.size() == 0);
            bus.fifo_data  = (fq.size() > 0) ? fq[0] : 8'h00;
        end
    end

    // Line decoder: finds a falling edge, samples every bit at its centre.
    logic [7:0] rxq[$];
    initial begin
        logic             prev_tx;
        logic             aborted;
        logic [NBITS-1:0] fb;
        prev_tx = 1'b1;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && prev_tx === 1'b1 && bus.tx === 1'b0) begin
                aborted = 1'b0;
                fb      = '0;
                for (int c = 1; c <= (NBITS - 1) * DIV + DIV / 2; c++) begin
                    @(negedge clock);
                    if (reset !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c % DIV == DIV / 2) fb[c / DIV] = bus.tx;
                end
                if (!aborted) begin
                    check("line_start_bit", fb[0], 1'b0);
                    check("line_stop_bit", fb[NBITS-1], 1'b1);
`ifdef FIFO_UART_TX_PARITY_EN
                    check("line_even_parity", fb[DW+1], ^fb[DW:1]);
`endif
                    rxq.push_back(fb[DW:1]);
                end
            end
            prev_tx = bus.tx;
        end
    end

    // Waits (bounded) for a frame, then checks it cycle by cycle against the
    // frame the byte should produce. w = negedges waited before busy rose.
    task automatic check_frame(input logic [7:0] d, input logic p, output int w);
        int   tx_errs;
        int   busy_errs;
        int   nrd;
        int   k;
        logic e;
        w = 0;
        while (bus.busy !== 1'b1 && w < 50) begin
            @(negedge clock);
            w++;
        end
        check("frame_start", bus.busy, 1'b1);
        if (bus.busy !== 1'b1) return;
        tx_errs = 0; busy_errs = 0; nrd = 0;
        for (int i = 0; i < FL; i++) begin
            k = i / DIV;
            if (k == 0)        e = 1'b0;
            else if (k <= DW)  e = d[k-1];
`ifdef FIFO_UART_TX_PARITY_EN
            else if (k == DW + 1) e = p;
`endif
            else               e = 1'b1;
            if (bus.tx !== e) tx_errs++;
            if (bus.busy !== 1'b1) busy_errs++;
            if (bus.fifo_read_en === 1'b1) nrd++;
            if (i == 0) check("read_strobe_first_cycle", bus.fifo_read_en, 1'b1);
            @(negedge clock);
        end
        check("frame_tx_bit_errors", tx_errs, 0);
        check("frame_busy_errors", busy_errs, 0);
        check("read_strobe_count", nrd, 1);
        check("after_frame_busy", bus.busy, 1'b0);
        check("after_frame_tx", bus.tx, 1'b1);
        check("decoded_present", rxq.size(), 1);
        if (rxq.size() > 0) check("decoded_byte", rxq.pop_front(), d);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;    // even parity of data
    } vec_t;

    vec_t vecs[6];
    int   w;
    int   errs;

    initial begin
        logic [7:0] expq[$];
        int         rises0;
        int         cnt;
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h03, 1'b0};
        vecs[3] = '{8'h01, 1'b1};
        vecs[4] = '{8'h80, 1'b1};
        vecs[5] = '{8'hFF, 1'b0};

        // Reset held with a byte pending.
        bus.tx_enable = 1'b1;
        fq.push_back(8'h96);
        errs = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_read_en !== 1'b0) errs++;
        end
        check("reset_hold_outputs", errs, 0);
        check("reset_tx", bus.tx, 1'b1);
        reset = 1'b1;
        check_frame(8'h96, 1'b0, w);
        check("reset_release_latency", w, 1);

        // Single-frame vectors.
        foreach (vecs[i]) begin
            fq.push_back(vecs[i].data);
            @(negedge clock);
            check("pre_start_idle", bus.busy, 1'b0);
            check_frame(vecs[i].data, vecs[i].par, w);
            check("start_latency", w, 1);
        end

        // Back-to-back frames: 10 stop cycles + 1 idle cycle between frames.
        fq.push_back(8'h01); fq.push_back(8'h80); fq.push_back(8'hFF);
        check_frame(8'h01, 1'b1, w);
        check_frame(8'h80, 1'b1, w);
        check("b2b_gap_1", w, 1);
        check_frame(8'hFF, 1'b0, w);
        check("b2b_gap_2", w, 1);

        // tx_enable low holds a pending byte; dropping it mid-frame only stops the next one.
        repeat (3) @(negedge clock);
        bus.tx_enable = 1'b0;
        fq.push_back(8'h55); fq.push_back(8'hAA);
        errs = 0;
        repeat (20) begin
            @(negedge clock);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_read_en !== 1'b0) errs++;
        end
        check("disabled_idle_errors", errs, 0);
        bus.tx_enable = 1'b1;
        fork
            check_frame(8'h55, 1'b0, w);
            begin
                repeat (45) @(negedge clock);
                bus.tx_enable = 1'b0;
            end
        join
        check("enable_latency", w, 1);
        errs = 0;
        repeat (30) begin
            @(negedge clock);
            if (bus.busy !== 1'b0 || bus.fifo_read_en !== 1'b0 || bus.tx !== 1'b1) errs++;
        end
        check("disabled_after_frame_errors", errs, 0);
        check("pending_kept", fq.size(), 1);
        bus.tx_enable = 1'b1;
        check_frame(8'hAA, 1'b0, w);
        check("reenable_latency", w, 1);

        // Reset in the middle of data bit 4.
        fq.push_back(8'h3C); fq.push_back(8'h5A);
        cnt = 0;
        while (bus.busy !== 1'b1 && cnt < 50) begin
            @(negedge clock);
            cnt++;
        end
        check("midreset_frame_started", bus.busy, 1'b1);
        repeat (55) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midreset_tx", bus.tx, 1'b1);
        check("midreset_busy", bus.busy, 1'b0);
        check("midreset_read_en", bus.fifo_read_en, 1'b0);
        check("midreset_byte_dropped", fq.size(), 1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        check_frame(8'h5A, 1'b0, w);
        check("midreset_restart_latency", w, 1);

        // Randomized traffic with random enable gating; every byte must come out in order.
        check("rx_empty_before_random", rxq.size(), 0);
        rises0 = rises;
        for (int it = 0; it < 20; it++) begin
            int n;
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                logic [7:0] b;
                b = 8'($urandom);
                fq.push_back(b);
                expq.push_back(b);
            end
            bus.tx_enable = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 150)) @(negedge clock);
        end
        bus.tx_enable = 1'b1;
        cnt = 0;
        while ((fq.size() > 0 || bus.busy !== 1'b0) && cnt < 12000) begin
            @(negedge clock);
            cnt++;
        end
        check("random_drained", (fq.size() == 0 && bus.busy === 1'b0), 1'b1);
        repeat (3) @(negedge clock);
        check("random_frame_count", rxq.size(), expq.size());
        check("random_strobe_count", rises - rises0, expq.size());
        for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
            check("random_byte", rxq[i], expq[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
